// File: rtl/mul_acc_stage_if.sv
// ---------------------------------------------------------------------------
// mul_acc_stage_if
// Bundles the upstream product stream, the block-length configuration and
// the downstream result stream of mul_acc_stage.
//   in_valid / in_ready / in_data / in_last : product stream (valid/ready)
//   cfg_len                                 : products per block
//   out_valid / out_ready / out_data /
//   out_count / out_ovf                     : result stream (valid/ready)
// Modports: master = producer/consumer environment, slave = the stage.
// ---------------------------------------------------------------------------
interface mul_acc_stage_if #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [LEN_W-1:0]  cfg_len;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [LEN_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_last, cfg_len, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, cfg_len, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/mul_acc_stage.sv
// ---------------------------------------------------------------------------
// mul_acc_stage
// Accumulates blocks of signed products into a signed sum. A block ends after
// cfg_len products (0 means 1) or on a product flagged in_last, whichever
// comes first. The result, the number of products summed and a sticky signed
// overflow flag are then held on the output stream until accepted.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset
//   bus  : mul_acc_stage_if.slave (product in, cfg_len, result out)
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module mul_acc_stage #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    mul_acc_stage_if.slave  bus
);
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    logic [1:0]       state_q,     state_d;
    logic [LEN_W-1:0] len_q,       len_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [LEN_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic [LEN_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q,   out_ovf_d;

    logic [ACC_W-1:0] in_ext_s;
    logic [ACC_W-1:0] sum_s;
    logic             add_ovf_s;
    logic [LEN_W-1:0] cnt_inc_s;
    logic [LEN_W-1:0] cfg_len_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             blk_end_s;

    // Sign-extend the product to accumulator width (no-op when widths match)
    generate
        if (ACC_W > DATA_W) begin : g_ext
            assign in_ext_s = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
        end else begin : g_noext
            assign in_ext_s = bus.in_data;
        end
    endgenerate

    // Datapath: wrapping add, overflow detect, handshakes, block-end decode
    always_comb begin
        sum_s      = acc_q + in_ext_s;
        // Overflow: operands share a sign and the wrapped result does not
        add_ovf_s  = (acc_q[ACC_W-1] == in_ext_s[ACC_W-1]) &&
                     (sum_s[ACC_W-1] != acc_q[ACC_W-1]);
        cnt_inc_s  = cnt_q + LEN_ONE;
        cfg_len_s  = (bus.cfg_len == LEN_ZERO) ? LEN_ONE : bus.cfg_len;
        in_xfer_s  = bus.in_valid && in_ready_q;
        out_xfer_s = out_valid_q && bus.out_ready;
        // Length match and in_last together still close a single block
        blk_end_s  = in_xfer_s && ((cnt_inc_s == len_q) || bus.in_last);
    end

    // Next-state logic for the INIT / ACC / SEND controller
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_INIT: begin
                // in_ready is raised by ACC, so it appears at the second edge
                state_d    = ST_ACC;
                len_d      = cfg_len_s;
                acc_d      = ACC_ZERO;
                cnt_d      = LEN_ZERO;
                ovf_d      = 1'b0;
                in_ready_d = 1'b0;
            end
            ST_ACC: begin
                if (blk_end_s) begin
                    state_d     = ST_SEND;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = sum_s;
                    out_count_d = cnt_inc_s;
                    out_ovf_d   = ovf_q || add_ovf_s;
                end else if (in_xfer_s) begin
                    in_ready_d = 1'b1;
                    acc_d      = sum_s;
                    cnt_d      = cnt_inc_s;
                    ovf_d      = ovf_q || add_ovf_s;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (out_xfer_s) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    len_d       = cfg_len_s;
                    acc_d       = ACC_ZERO;
                    cnt_d       = LEN_ZERO;
                    ovf_d       = 1'b0;
                end else begin
                    in_ready_d  = 1'b0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            len_q       <= LEN_ONE;
            acc_q       <= ACC_ZERO;
            cnt_q       <= LEN_ZERO;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= ACC_ZERO;
            out_count_q <= LEN_ZERO;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
